// File: rtl/mor1kx_dpram_rmw_ctrl.sv
// Initiator-side controller for a 1-cycle, write-first true dual-port RAM: clears the array
// two words per cycle, then serves reads, full writes and byte-masked read-modify-writes.
module mor1kx_dpram_rmw_ctrl #(
  parameter int unsigned           ADDR_WIDTH  = 8,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    invalidate_i,
  output logic                    busy_o,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [DATA_WIDTH/8-1:0] req_bsel_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdat_i,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_dat_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_a_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_b_o,
  output logic                    ram_we_a_o,
  output logic                    ram_we_b_o,
  output logic [DATA_WIDTH-1:0]   ram_din_a_o,
  output logic [DATA_WIDTH-1:0]   ram_din_b_o,
  input  logic [DATA_WIDTH-1:0]   ram_dout_a_i,
  input  logic [DATA_WIDTH-1:0]   ram_dout_b_i
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned CntW     = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;

  typedef enum logic [1:0] {StClear, StIdle, StRmw} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  inv_pend_q, inv_pend_d;
  logic                  busy_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_dat_q;
  logic [ADDR_WIDTH-1:0] rmw_addr_q;
  logic [DATA_WIDTH-1:0] rmw_wdat_q;
  logic [NumBytes-1:0]   rmw_bsel_q;

  logic                  ready;
  logic                  accept;
  logic                  full_word;
  logic                  start_rmw;
  logic                  cnt_last;
  logic [ADDR_WIDTH-1:0] clr_addr_a, clr_addr_b;
  logic [DATA_WIDTH-1:0] merged;
  logic                  unused_dout_b;

  // Port B read data is never consumed: port B only ever writes.
  assign unused_dout_b = ^ram_dout_b_i;

  // Each clear cycle covers an even/odd address pair.
  if (ADDR_WIDTH > 1) begin : g_cnt
    assign clr_addr_a = {cnt_q, 1'b0};
    assign clr_addr_b = {cnt_q, 1'b1};
    assign cnt_last   = &cnt_q;
  end else begin : g_nocnt
    assign clr_addr_a = '0;
    assign clr_addr_b = '1;
    assign cnt_last   = 1'b1;
  end

  for (genvar i = 0; i < NumBytes; i++) begin : g_merge
    assign merged[8*i +: 8] = rmw_bsel_q[i] ? rmw_wdat_q[8*i +: 8] : ram_dout_a_i[8*i +: 8];
  end

  assign ready     = (state_q == StIdle) && !inv_pend_q && !invalidate_i && !rst;
  assign accept    = req_valid_i && ready;
  assign full_word = &req_bsel_i;
  assign start_rmw = accept && req_we_i && !full_word;

  assign req_ready_o = ready;
  assign busy_o      = busy_q || rst;
  assign rsp_valid_o = rsp_valid_q && !rst;
  assign rsp_dat_o   = rsp_valid_q ? ram_dout_a_i : rsp_dat_q;

  always_comb begin
    ram_addr_a_o = req_addr_i;
    ram_addr_b_o = rmw_addr_q;
    ram_we_a_o   = 1'b0;
    ram_we_b_o   = 1'b0;
    ram_din_a_o  = req_wdat_i;
    ram_din_b_o  = merged;
    unique case (state_q)
      StClear: begin
        ram_addr_a_o = clr_addr_a;
        ram_addr_b_o = clr_addr_b;
        ram_we_a_o   = 1'b1;
        ram_we_b_o   = 1'b1;
        ram_din_a_o  = CLEAR_VALUE;
        ram_din_b_o  = CLEAR_VALUE;
      end
      StIdle: ram_we_a_o = accept && req_we_i && full_word;
      StRmw: begin
        ram_addr_a_o = rmw_addr_q;
        ram_we_b_o   = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      ram_we_a_o = 1'b0;
      ram_we_b_o = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inv_pend_d = inv_pend_q || invalidate_i;
    unique case (state_q)
      StClear: begin
        if (invalidate_i) begin
          cnt_d      = '0;
          inv_pend_d = 1'b0;
        end else if (cnt_last) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StIdle: begin
        if (inv_pend_q || invalidate_i) begin
          state_d    = StClear;
          cnt_d      = '0;
          inv_pend_d = 1'b0;
        end else if (start_rmw) begin
          state_d = StRmw;
        end
      end
      StRmw: begin
        // The merge write always lands before any pending clear starts.
        if (inv_pend_q || invalidate_i) begin
          state_d    = StClear;
          cnt_d      = '0;
          inv_pend_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StClear;
      cnt_q       <= '0;
      inv_pend_q  <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rmw_addr_q  <= '0;
      rmw_wdat_q  <= '0;
      rmw_bsel_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inv_pend_q  <= inv_pend_d;
      busy_q      <= (state_d == StClear) || inv_pend_d;
      rsp_valid_q <= accept && !req_we_i;
      if (rsp_valid_q) rsp_dat_q <= ram_dout_a_i;
      if (start_rmw) begin
        rmw_addr_q <= req_addr_i;
        rmw_wdat_q <= req_wdat_i;
        rmw_bsel_q <= req_bsel_i;
      end
    end
  end

endmodule

// File: tb/tb_mor1kx_dpram_rmw_ctrl.sv
// Bench for mor1kx_dpram_rmw_ctrl: word-level memory model plus response queue, checked every
// cycle, with directed scenarios pinned by literal expectations.
module tb_mor1kx_dpram_rmw_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst, invalidate_i, busy_o;
  logic          req_valid_i, req_ready_o, req_we_i;
  logic [3:0]    req_bsel_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdat_i;
  logic          rsp_valid_o;
  logic [DW-1:0] rsp_dat_o;
  logic [AW-1:0] ram_addr_a_o, ram_addr_b_o;
  logic          ram_we_a_o, ram_we_b_o;
  logic [DW-1:0] ram_din_a_o, ram_din_b_o, ram_dout_a_i, ram_dout_b_i;

  always #5 clk = ~clk;

  mor1kx_dpram_rmw_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_VALUE('0)) dut (
    .clk          (clk),
    .rst          (rst),
    .invalidate_i (invalidate_i),
    .busy_o       (busy_o),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_bsel_i   (req_bsel_i),
    .req_addr_i   (req_addr_i),
    .req_wdat_i   (req_wdat_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_dat_o    (rsp_dat_o),
    .ram_addr_a_o (ram_addr_a_o),
    .ram_addr_b_o (ram_addr_b_o),
    .ram_we_a_o   (ram_we_a_o),
    .ram_we_b_o   (ram_we_b_o),
    .ram_din_a_o  (ram_din_a_o),
    .ram_din_b_o  (ram_din_b_o),
    .ram_dout_a_i (ram_dout_a_i),
    .ram_dout_b_i (ram_dout_b_i)
  );

  // Write-first dual-port RAM, preloaded with non-zero junk so the clear is observable.
  logic [DW-1:0] ram [NW];
  logic          fill;
  always @(posedge clk) begin
    if (fill) begin
      for (int a = 0; a < NW; a++) ram[a] <= 32'hA5A50000 | 32'(a);
    end else begin
      if (ram_we_a_o) ram[ram_addr_a_o] <= ram_din_a_o;
      if (ram_we_b_o) ram[ram_addr_b_o] <= ram_din_b_o;
    end
    ram_dout_a_i <= ram_we_a_o ? ram_din_a_o : ram[ram_addr_a_o];
    ram_dout_b_i <= ram_we_b_o ? ram_din_b_o : ram[ram_addr_b_o];
  end

  typedef struct {
    int          due;
    logic [31:0] dat;
  } exp_t;

  logic [DW-1:0] mem_m [NW];
  exp_t          exp_q[$];
  int            cyc = 0;
  int            tests = 0;
  int            fails = 0;
  bit            chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endfunction

  function automatic void clr_model();
    for (int a = 0; a < NW; a++) mem_m[a] = '0;
  endfunction

  function automatic void push_read(input logic [AW-1:0] a);
    exp_t e;
    e.due = cyc + 1;
    e.dat = mem_m[a];
    exp_q.push_back(e);
  endfunction

  // Every cycle: a response appears exactly when one is due, with the model's data.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("rsp_dat", rsp_dat_o, exp_q[0].dat);
        void'(exp_q.pop_front());
      end else begin
        chk("rsp_idle_valid", 32'(rsp_valid_o), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid_i = 1'b0;
  endtask

  // Present a request until accepted; returns the acceptance cycle, inputs left driven.
  task automatic do_req(input logic we, input logic [3:0] bsel, input logic [AW-1:0] addr,
                        input logic [31:0] wdat, output int acc);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_bsel_i  = bsel;
    req_addr_i  = addr;
    req_wdat_i  = wdat;
    acc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        acc = cyc;
        if (!we) push_read(addr);
        else for (int b = 0; b < 4; b++) if (bsel[b]) mem_m[addr][8*b +: 8] = wdat[8*b +: 8];
        break;
      end
    end
    if (acc < 0) chk("req_accept_timeout", 32'd0, 32'd1);
    tick();
  endtask

  // Counts clear cycles up to the first non-busy negedge, checking the port pattern.
  task automatic count_clear(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy_o) break;
      chk("clr_ready", 32'(req_ready_o), 32'd0);
      chk("clr_we", 32'({ram_we_a_o, ram_we_b_o}), 32'd3);
      chk("clr_addr_a", 32'(ram_addr_a_o), 32'(2 * n));
      chk("clr_addr_b", 32'(ram_addr_b_o), 32'(2 * n + 1));
      chk("clr_din", ram_din_a_o | ram_din_b_o, 32'd0);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int acc, acc2, acc3, n;
    fill = 1'b1;
    rst = 1'b1;
    invalidate_i = 1'b0;
    req_valid_i = 1'b0;
    req_we_i = 1'b0;
    req_bsel_i = '0;
    req_addr_i = '0;
    req_wdat_i = '0;
    clr_model();

    // Reset clear, with a read held pending throughout.
    tick();
    fill = 1'b0;
    chk_en = 1'b1;
    req_valid_i = 1'b1;
    req_we_i = 1'b0;
    req_addr_i = 4'd0;
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd1);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_we", 32'({ram_we_a_o, ram_we_b_o}), 32'd0);
    tick();
    rst = 1'b0;
    count_clear(n);
    chk("reset_clear_len", 32'(n), 32'd8);
    chk("post_clear_ready", 32'(req_ready_o), 32'd1);
    if (req_ready_o) push_read(4'd0);
    tick();
    idle();
    do_req(1'b0, 4'hF, 4'd9, '0, acc);
    idle();
    @(negedge clk);
    chk("cleared_addr9", rsp_dat_o, 32'd0);
    tick();

    // Full write followed immediately by a read of the same word, then a hold check.
    do_req(1'b1, 4'hF, 4'd3, 32'hDEADBEEF, acc);
    do_req(1'b0, 4'hF, 4'd3, '0, acc2);
    chk("wr_rd_back_to_back", 32'(acc2), 32'(acc + 1));
    idle();
    req_addr_i = 4'd0;
    @(negedge clk);
    chk("rd3_valid", 32'(rsp_valid_o), 32'd1);
    chk("rd3_dat", rsp_dat_o, 32'hDEADBEEF);
    @(negedge clk);
    chk("rsp_dat_hold", rsp_dat_o, 32'hDEADBEEF);
    tick();

    // Partial write as read-modify-write.
    do_req(1'b1, 4'hF, 4'd5, 32'h11223344, acc);
    do_req(1'b1, 4'b0101, 4'd5, 32'hAABBCCDD, acc);
    idle();
    @(negedge clk);
    chk("rmw_ready_low", 32'(req_ready_o), 32'd0);
    chk("rmw_we_b", 32'(ram_we_b_o), 32'd1);
    chk("rmw_addr_b", 32'(ram_addr_b_o), 32'd5);
    chk("rmw_din_b", ram_din_b_o, 32'h11BB33DD);
    tick();
    do_req(1'b0, 4'hF, 4'd5, '0, acc2);
    chk("rmw_next_accept", 32'(acc2), 32'(acc + 2));
    idle();
    @(negedge clk);
    chk("rmw_readback", rsp_dat_o, 32'h11BB33DD);
    tick();

    // All-zero byte select still writes, leaving the word unchanged.
    do_req(1'b1, 4'h0, 4'd5, 32'hFFFFFFFF, acc);
    idle();
    @(negedge clk);
    chk("zero_bsel_we_b", 32'(ram_we_b_o), 32'd1);
    chk("zero_bsel_din_b", ram_din_b_o, 32'h11BB33DD);
    tick();

    // Back-to-back reads.
    do_req(1'b1, 4'hF, 4'd1, 32'h01010101, acc);
    do_req(1'b1, 4'hF, 4'd2, 32'h02020202, acc);
    do_req(1'b1, 4'hF, 4'd3, 32'h03030303, acc);
    do_req(1'b0, 4'hF, 4'd1, '0, acc);
    do_req(1'b0, 4'hF, 4'd2, '0, acc2);
    do_req(1'b0, 4'hF, 4'd3, '0, acc3);
    idle();
    chk("b2b_accept_2", 32'(acc2), 32'(acc + 1));
    chk("b2b_accept_3", 32'(acc3), 32'(acc + 2));
    @(negedge clk);
    chk("b2b_third_dat", rsp_dat_o, 32'h03030303);
    tick();

    // Invalidate raised in the RMW cycle: merge write lands, then a full clear.
    do_req(1'b1, 4'b0011, 4'd5, 32'h99998888, acc);
    idle();
    invalidate_i = 1'b1;
    @(negedge clk);
    chk("inv_rmw_we_b", 32'(ram_we_b_o), 32'd1);
    chk("inv_rmw_din_b", ram_din_b_o, 32'h11BB8888);
    tick();
    invalidate_i = 1'b0;
    clr_model();
    count_clear(n);
    chk("inv_clear_len", 32'(n), 32'd8);
    tick();
    do_req(1'b0, 4'hF, 4'd5, '0, acc);
    idle();
    @(negedge clk);
    chk("inv_addr5_zero", rsp_dat_o, 32'd0);
    tick();

    // Invalidate beats a simultaneous request; then reset lands in clear cycle 4.
    req_valid_i = 1'b1;
    req_we_i = 1'b1;
    req_bsel_i = 4'hF;
    req_addr_i = 4'd7;
    req_wdat_i = 32'h77777777;
    invalidate_i = 1'b1;
    @(negedge clk);
    chk("inv_dominates_ready", 32'(req_ready_o), 32'd0);
    tick();
    invalidate_i = 1'b0;
    idle();
    clr_model();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("pre_rst_busy", 32'(busy_o), 32'd1);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_we", 32'({ram_we_a_o, ram_we_b_o}), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd1);
    tick();
    rst = 1'b0;
    count_clear(n);
    chk("mid_rst_clear_len", 32'(n), 32'd8);
    tick();
    do_req(1'b0, 4'hF, 4'd7, '0, acc);
    idle();
    tick();
    tick();

    for (int a = 0; a < NW; a++) chk("ram_contents", ram[a], mem_m[a]);
    chk("rsp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
